// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request and register-file write bundle for regfile_wb_arbiter.
// master = requesters/observer side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32
);
  localparam int AW = $clog2(REG_DEPTH);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [AW-1:0]         alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [AW-1:0]         lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  rf_we;
  logic [AW-1:0]         rf_write_addr;
  logic [DATA_WIDTH-1:0] rf_rd_in;
  logic                  pending;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_write_addr, rf_rd_in, pending
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_write_addr, rf_rd_in, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and LSU.
// Each requester has its own FIFO; one registered write per cycle.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(REG_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  logic                  in_valid [2];
  logic [AW-1:0]         in_addr  [2];
  logic [DATA_WIDTH-1:0] in_data  [2];

  logic [AW-1:0]         q_addr [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [2][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [CW-1:0]         cnt    [2];

  logic full     [2];
  logic nonempty [2];
  logic push     [2];
  logic pop      [2];

  req_e                  last_grant;
  req_e                  gnt_sel;
  logic                  gnt_valid;
  logic                  gnt_idx;
  logic [AW-1:0]         gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign in_valid[0] = bus.alu_valid;
  assign in_addr[0]  = bus.alu_addr;
  assign in_data[0]  = bus.alu_data;
  assign in_valid[1] = bus.lsu_valid;
  assign in_addr[1]  = bus.lsu_addr;
  assign in_data[1]  = bus.lsu_data;

  // x0 writes are accepted on the handshake but never enqueued
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (cnt[i] == CW'(FIFO_DEPTH));
      nonempty[i] = (cnt[i] != '0);
      push[i]     = in_valid[i] && !full[i] && (in_addr[i] != '0);
    end
  end

  always_comb begin
    gnt_valid = nonempty[0] || nonempty[1];
    gnt_sel   = REQ_ALU;
    unique case (1'b1)
      (nonempty[0] && nonempty[1]):
        gnt_sel = (last_grant == REQ_ALU) ? REQ_LSU : REQ_ALU;
      (nonempty[0] && !nonempty[1]):
        gnt_sel = REQ_ALU;
      (!nonempty[0] && nonempty[1]):
        gnt_sel = REQ_LSU;
      default:
        gnt_sel = REQ_ALU;
    endcase
  end

  assign gnt_idx  = (gnt_sel == REQ_LSU);
  assign gnt_addr = q_addr[gnt_idx][rd_ptr[gnt_idx]];
  assign gnt_data = q_data[gnt_idx][rd_ptr[gnt_idx]];
  assign pop[0]   = gnt_valid && (gnt_sel == REQ_ALU);
  assign pop[1]   = gnt_valid && (gnt_sel == REQ_LSU);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_addr[i][wr_ptr[i]] <= in_addr[i];
        q_data[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_LSU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      we_q <= gnt_valid;
      if (gnt_valid) begin
        last_grant <= gnt_sel;
        addr_q     <= gnt_addr;
        data_q     <= gnt_data;
      end
    end
  end

  assign bus.alu_ready     = !full[0];
  assign bus.lsu_ready     = !full[1];
  assign bus.rf_we         = we_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_rd_in      = data_q;
  assign bus.pending       = nonempty[0] || nonempty[1] || we_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Writes are captured on negedges while rf_we is high.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [4:0]  wa_q [$];
  logic [31:0] wd_q [$];

  regfile_wb_arbiter_if #(.DATA_WIDTH(32), .REG_DEPTH(32)) bus ();

  regfile_wb_arbiter #(
    .DATA_WIDTH(32),
    .REG_DEPTH (32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      wa_q.push_back(bus.rf_write_addr);
      wd_q.push_back(bus.rf_rd_in);
    end
  end

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_data  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd7;
    bus.alu_data  = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rf_we !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_we[%0d] got %b want 0", i, bus.rf_we);
      end
      n_cmp++;
      if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready[%0d] got %b%b want 11",
                 i, bus.alu_ready, bus.lsu_ready);
      end
      n_cmp++;
      if (bus.pending !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_pending[%0d] got %b want 0", i, bus.pending);
      end
      n_cmp++;
      if (bus.rf_write_addr !== 5'd0 || bus.rf_rd_in !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_out[%0d] got %h/%h want 00/00000000",
                 i, bus.rf_write_addr, bus.rf_rd_in);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_alu();
    apply_reset();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rf_we !== (i == 2)) begin
        n_bad++;
        $display("FAIL single_we[%0d] got %b want %b", i, bus.rf_we, (i == 2));
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.pending !== 1'b1) begin
          n_bad++;
          $display("FAIL single_pending got %b want 1", bus.pending);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (bus.rf_write_addr !== 5'd5 || bus.rf_rd_in !== 32'hDEAD_BEEF) begin
          n_bad++;
          $display("FAIL single_wr got %h/%h want 05/deadbeef",
                   bus.rf_write_addr, bus.rf_rd_in);
        end
      end
      @(posedge clk);
      #1;
      if (i == 0) bus.alu_valid = 1'b0;
    end
  endtask

  task automatic test_contention();
    int   ia = 0;
    int   ib = 0;
    int   cyc = 0;
    logic ra, rb;
    logic saw_stall = 1'b0;
    logic [4:0]  ea;
    logic [31:0] ed;
    apply_reset();
    while ((ia < 4 || ib < 4) && cyc < 40) begin
      bus.alu_valid = (ia < 4);
      bus.alu_addr  = 5'(1 + ia);
      bus.alu_data  = 32'hA0A0_0000 + 32'(ia);
      bus.lsu_valid = (ib < 4);
      bus.lsu_addr  = 5'(16 + ib);
      bus.lsu_data  = 32'hB0B0_0000 + 32'(ib);
      @(negedge clk);
      ra = bus.alu_ready;
      rb = bus.lsu_ready;
      if (!ra || !rb) saw_stall = 1'b1;
      @(posedge clk);
      if (bus.alu_valid && ra) ia++;
      if (bus.lsu_valid && rb) ib++;
      #1;
      cyc++;
    end
    idle_inputs();
    drain(12);
    n_cmp++;
    if (cyc >= 40) begin
      n_bad++;
      $display("FAIL contend_timeout got %0d cycles want <40", cyc);
    end
    n_cmp++;
    if (saw_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL contend_backpressure got %b want 1", saw_stall);
    end
    n_cmp++;
    if (wa_q.size() != 8) begin
      n_bad++;
      $display("FAIL contend_count got %0d want 8", wa_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ea = (k % 2 == 0) ? 5'(1 + k / 2) : 5'(16 + k / 2);
        ed = (k % 2 == 0) ? 32'hA0A0_0000 + 32'(k / 2)
                          : 32'hB0B0_0000 + 32'(k / 2);
        n_cmp++;
        if (wa_q[k] !== ea || wd_q[k] !== ed) begin
          n_bad++;
          $display("FAIL contend_wr[%0d] got %h/%h want %h/%h",
                   k, wa_q[k], wd_q[k], ea, ed);
        end
      end
    end
  endtask

  task automatic test_lsu_stream();
    int   k = 0;
    int   cyc = 0;
    logic rb;
    apply_reset();
    while (k < 4 && cyc < 20) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_addr  = 5'(9 + k);
      bus.lsu_data  = 32'hC0DE_0000 + 32'(k);
      @(negedge clk);
      rb = bus.lsu_ready;
      n_cmp++;
      if (rb !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_ready[%0d] got %b want 1", cyc, rb);
      end
      @(posedge clk);
      if (rb) k++;
      #1;
      cyc++;
    end
    idle_inputs();
    drain(6);
    n_cmp++;
    if (cyc != 4) begin
      n_bad++;
      $display("FAIL stream_cycles got %0d want 4", cyc);
    end
    n_cmp++;
    if (wa_q.size() != 4) begin
      n_bad++;
      $display("FAIL stream_count got %0d want 4", wa_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (wa_q[j] !== 5'(9 + j) || wd_q[j] !== 32'hC0DE_0000 + 32'(j)) begin
          n_bad++;
          $display("FAIL stream_wr[%0d] got %h/%h want %h/%h", j, wa_q[j],
                   wd_q[j], 5'(9 + j), 32'hC0DE_0000 + 32'(j));
        end
      end
    end
  endtask

  task automatic test_x0_discard();
    apply_reset();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.alu_addr = 5'd3;
    bus.alu_data = 32'h0000_0055;
    @(negedge clk);
    n_cmp++;
    if (bus.pending !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_pending got %b want 0", bus.pending);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    drain(5);
    n_cmp++;
    if (wa_q.size() != 1) begin
      n_bad++;
      $display("FAIL x0_count got %0d want 1", wa_q.size());
    end else begin
      n_cmp++;
      if (wa_q[0] !== 5'd3 || wd_q[0] !== 32'h55) begin
        n_bad++;
        $display("FAIL x0_wr got %h/%h want 03/00000055", wa_q[0], wd_q[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd4;
    bus.alu_data  = 32'hAAAA_0004;
    bus.lsu_valid = 1'b1;
    bus.lsu_addr  = 5'd20;
    bus.lsu_data  = 32'hBBBB_0014;
    drain(4);
    @(negedge clk);
    n_cmp++;
    if (bus.pending !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_busy got %b want 1", bus.pending);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    n_cmp++;
    if (bus.rf_we !== 1'b0 || bus.pending !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state got we=%b pend=%b want 0/0",
               bus.rf_we, bus.pending);
    end
    n_cmp++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_ready got %b%b want 11",
               bus.alu_ready, bus.lsu_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    drain(6);
    n_cmp++;
    if (wa_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_stale got %0d writes want 0", wa_q.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_alu();
    test_contention();
    test_lsu_stream();
    test_x0_discard();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
